mem_rr_arbiter: RTL and testbench

Shares one single-port synchronous RAM between NREQ requesters. The RAM has 1-cycle registered read, read-first on write, and synchronous clear on rst. The arbiter sits between the requesters and the RAM. It gives each requester a valid/ready request channel and a read-response strobe, and grants one access per cycle with round-robin fairness. It fully pipelines back-to-back accesses (one per clk).

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/mem_rr_arbiter.sv | 50 +++++
 tb/tb_mem_rr_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and round-robin search for the memory arbiter
package mem_arb_pkg;
  localparam int MAX_NREQ = 8;
  typedef logic [$clog2(MAX_NREQ)-1:0] req_idx_t;
  typedef struct packed {
    logic     found;
    req_idx_t idx;
  } pick_t;
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid, input req_idx_t ptr, input int n);
    pick_t    r;
    req_idx_t i;
    r = '0;
    i = ptr;
    for (int k = 0; k < MAX_NREQ; k++) begin
      if (k < n && !r.found && valid[i]) begin
        r.found = 1'b1;
        r.idx   = i;
      end
      i = (i == req_idx_t'(n - 1)) ? '0 : i + 1'b1;
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over N requesters, owns the priority pointer
module rr_arbiter import mem_arb_pkg::*; #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  valid_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_o
);
  logic [IW-1:0] ptr_q;
  pick_t         pick;
  // first valid requester at or after ptr, wrapping explicitly at N-1
  always_comb begin
    pick        = rr_pick(MAX_NREQ'(valid_i), req_idx_t'(ptr_q), N);
    grant_idx_o = IW'(pick.idx);
    any_o       = pick.found;
    grant_o     = pick.found ? N'(1) << grant_idx_o : '0;
  end
  // pointer moves just past the winner; idle cycles leave it alone
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else if (advance_i && any_o) ptr_q <= (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
  end
endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin sharing of one single-port sync RAM between NREQ requesters
module mem_rr_arbiter import mem_arb_pkg::*; #(
  parameter int LEN = 256,
  parameter int DW = 8,
  parameter int NREQ = 2,
  localparam int AW = $clog2(LEN),
  localparam int IW = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_wr,
  input  logic [NREQ-1:0][AW-1:0]   req_addr,
  input  logic [NREQ-1:0][DW-1:0]   req_d,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [DW-1:0]             rsp_q,
  output logic [AW-1:0]             m_addr,
  output logic [DW-1:0]             m_d,
  output logic                      m_wr,
  input  logic [DW-1:0]             m_q
);
  logic [NREQ-1:0] grant, rsp_valid_q;
  logic [IW-1:0]   idx;
  logic            any, go;
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (req_valid),
    .advance_i  (~rst),
    .grant_o    (grant),
    .grant_idx_o(idx),
    .any_o      (any)
  );
  // winner drives the RAM; reset and idle cycles park it at zero with no write
  always_comb begin
    go        = any & ~rst;
    req_ready = go ? grant : '0;
    m_addr    = go ? req_addr[idx] : '0;
    m_d       = go ? req_d[idx] : '0;
    m_wr      = go & req_wr[idx];
    rsp_valid = rst ? '0 : rsp_valid_q;
    rsp_q     = m_q;
  end
  // read strobe lines up with the RAM's one-cycle registered output
  always_ff @(posedge clk) begin
    if (rst) rsp_valid_q <= '0;
    else rsp_valid_q <= (go && !req_wr[idx]) ? grant : '0;
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: scoreboard bench with a 64x8 RAM model and random soak
module tb_mem_rr_arbiter;
  localparam int LEN = 64, DW = 8, NREQ = 2, AW = 6;
  typedef struct {int idx; logic [DW-1:0] d;} rsp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_wr = '0, req_ready, rsp_valid, done;
  logic [NREQ-1:0][AW-1:0] req_addr = '0;
  logic [NREQ-1:0][DW-1:0] req_d = '0;
  logic [DW-1:0] rsp_q, m_d, m_q;
  logic [AW-1:0] m_addr;
  logic m_wr;
  logic [DW-1:0] ram [LEN];
  logic [DW-1:0] ref_mem [LEN];
  rsp_t q[$];
  int m_ptr = 0;
  int wcnt [NREQ];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_rr_arbiter #(.LEN(LEN), .DW(DW), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_d(req_d), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_q(rsp_q),
    .m_addr(m_addr), .m_d(m_d), .m_wr(m_wr), .m_q(m_q)
  );
  // RAM: registered read, read-first on write, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LEN; i++) ram[i] <= '0;
      m_q <= '0;
    end else begin
      m_q <= ram[m_addr];
      if (m_wr) ram[m_addr] <= m_d;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction
  // reference model: advances once per clock from the requests presented
  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_ptr = 0;
      for (int i = 0; i < LEN; i++) ref_mem[i] = '0;
      q.delete();
    end else begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) begin
        if (req_wr[g]) ref_mem[req_addr[g]] = req_d[g];
        else q.push_back('{g, ref_mem[req_addr[g]]});
        m_ptr = (g + 1) % NREQ;
      end
    end
  end
  // grant and RAM-drive checker plus wait-time bound
  always @(negedge clk) begin
    int g, gi;
    g = pick(req_valid, m_ptr);
    gi = (g < 0) ? 0 : g;
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_m_wr", m_wr, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_d", m_d, 0);
      for (int i = 0; i < NREQ; i++) wcnt[i] = 0;
    end else begin
      chk("ready", req_ready, (g < 0) ? 0 : (1 << g));
      chk("m_wr", m_wr, (g < 0) ? 0 : req_wr[gi]);
      chk("m_addr", m_addr, (g < 0) ? 0 : req_addr[gi]);
      chk("m_d", m_d, (g < 0) ? 0 : req_d[gi]);
      for (int i = 0; i < NREQ; i++) begin
        wcnt[i] = (req_valid[i] && !req_ready[i]) ? wcnt[i] + 1 : 0;
        if (req_valid[i]) chk("wait_bound", wcnt[i] <= NREQ - 1, 1);
      end
    end
  end
  // response monitor: pops the scoreboard whenever a response is due
  always @(negedge clk) begin
    rsp_t e;
    if (rst) begin
      chk("rsp_in_rst", rsp_valid, 0);
      q.delete();
    end else if (q.size() == 0) chk("rsp_idle", rsp_valid, 0);
    else begin
      e = q.pop_front();
      chk("rsp_who", rsp_valid, 1 << e.idx);
      chk("rsp_data", rsp_q, e.d);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic v, input logic wr, input int a, input int d);
    req_valid[i] = v;
    req_wr[i] = wr;
    req_addr[i] = AW'(a);
    req_d[i] = DW'(d);
  endtask
  initial begin
    set_req(0, 1, 0, 3, 0);
    set_req(1, 1, 0, 4, 0);
    rst = 1'b1;
    tick();
    @(negedge clk) chk("t1_ready", req_ready, 0);
    tick();
    @(negedge clk) chk("t1_m_wr", m_wr, 0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk) chk("t1_rsp_after", rsp_valid, 0);
    tick();
    set_req(0, 1, 1, 5, 8'hA5);
    @(negedge clk) chk("t2_wr_ready", req_ready, 2'b01);
    tick();
    set_req(0, 1, 0, 5, 0);
    @(negedge clk) chk("t2_rd_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t2_rsp_valid", rsp_valid, 2'b01);
    chk("t2_rsp_q", rsp_q, 8'hA5);
    tick();
    set_req(0, 1, 1, 1, 8'h11);
    tick();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 1, 1, 2, 8'h22);
    tick();
    set_req(0, 1, 0, 1, 0);
    set_req(1, 1, 0, 2, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t3_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) begin
        chk("t3_rsp_valid", rsp_valid, (k % 2) ? 2'b01 : 2'b10);
        chk("t3_rsp_q", rsp_q, (k % 2) ? 8'h11 : 8'h22);
      end
      tick();
    end
    req_valid = '0;
    tick();
    set_req(1, 1, 1, 9, 8'h3C);
    tick();
    set_req(1, 0, 0, 0, 0);
    set_req(0, 1, 0, 9, 0);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t4_rsp_valid", rsp_valid, 2'b01);
    chk("t4_rsp_q", rsp_q, 8'h3C);
    tick();
    set_req(0, 1, 0, 1, 0);
    tick();
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk) chk("t5_drop", rsp_valid, 0);
    tick();
    rst = 1'b0;
    @(negedge clk) chk("t5_after", rsp_valid, 0);
    tick();
    set_req(0, 1, 0, 1, 0);
    set_req(1, 1, 0, 2, 0);
    @(negedge clk) chk("t5_ptr0", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t5_rsp_valid", rsp_valid, 2'b01);
    chk("t5_rsp_q", rsp_q, 0);
    tick();
    req_valid = '0;
    tick();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk) done = req_valid & req_ready;
      tick();
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] || done[i]) begin
          if ($urandom_range(9) < 7) set_req(i, 1, 1'($urandom_range(1)), $urandom_range(15), $urandom_range(255));
          else req_valid[i] = 1'b0;
        end
    end
    @(negedge clk) done = req_valid & req_ready;
    tick();
    req_valid = req_valid & ~done;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk) done = req_valid & req_ready;
      tick();
      req_valid = req_valid & ~done;
    end
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
